// File: rtl/alu_operand_stage.sv
// Operand-latch / status-register sequencer wrapped around the combinational 6502 ALU.
// Optional BCD adjust step for SUM is compiled in when the DECIMAL_EN macro is defined.
module alu_operand_stage #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter logic [7:0] DATA_RESET  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_inv,
    input  logic       req_cin,
    input  logic       req_cin_sel,
    input  logic [3:0] req_fmask,
    input  logic       dec_mode,

    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    output logic       alu_inv,
    output logic       alu_cin,
    input  logic [7:0] alu_out,
    input  logic       alu_cout,
    input  logic       alu_zero,
    input  logic       alu_ovf,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       p_n,
    output logic       p_v,
    output logic       p_z,
    output logic       p_c
);

`ifdef DECIMAL_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_ADJ  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [3:0] OP_SUM = 4'd1;
    localparam logic [3:0] OP_SR  = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [3:0] fmask;
    logic       dec_req;
    logic       accept;
    logic       go_adj;
    logic       carry_op;
    logic [8:0] adj_res;

    // Decimal correction of a binary SUM result; returns {carry, adjusted byte}.
    function automatic logic [8:0] bcd_adjust(input logic [7:0] bin,
                                              input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic       inv,
                                              input logic       cin,
                                              input logic       cout);
        logic [7:0] bx;
        logic [4:0] lo_sum;
        logic       half;
        logic       lo_adj;
        logic       hi_adj;
        logic [7:0] res;
        bx     = inv ? ~b : b;
        lo_sum = {1'b0, a[3:0]} + {1'b0, bx[3:0]} + {4'b0000, cin};
        half   = lo_sum[4];
        if (!inv) begin
            lo_adj = (bin[3:0] > 4'd9) || half;
            hi_adj = (bin > 8'h99) || cout;
            res    = bin + (lo_adj ? 8'h06 : 8'h00) + (hi_adj ? 8'h60 : 8'h00);
            return {hi_adj, res};
        end else begin
            res = bin - (half ? 8'h00 : 8'h06) - (cout ? 8'h00 : 8'h60);
            return {cout, res};
        end
    endfunction

    assign req_ready = (state == ST_IDLE) || ((state == ST_HOLD) && rsp_ready);
    assign rsp_valid = (state == ST_HOLD);
    assign accept    = req_valid && req_ready;
    assign go_adj    = DEC_EN && dec_req;
    assign carry_op  = (alu_op == OP_SUM) || (alu_op == OP_SR) || (alu_op == OP_ROR);
    assign adj_res   = bcd_adjust(alu_out, alu_a, alu_b, alu_inv, alu_cin, alu_cout);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (req_valid) state_nx = ST_EXEC;
            ST_EXEC: state_nx = go_adj ? ST_ADJ : ST_HOLD;
            ST_ADJ:  state_nx = ST_HOLD;
            ST_HOLD: if (rsp_ready) state_nx = req_valid ? ST_EXEC : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            alu_a    <= DATA_RESET;
            alu_b    <= DATA_RESET;
            alu_op   <= 4'd0;
            alu_inv  <= 1'b0;
            alu_cin  <= 1'b0;
            fmask    <= 4'd0;
            dec_req  <= 1'b0;
            rsp_data <= DATA_RESET;
            p_n      <= RESET_FLAGS[3];
            p_v      <= RESET_FLAGS[2];
            p_z      <= RESET_FLAGS[1];
            p_c      <= RESET_FLAGS[0];
        end else begin
            state <= state_nx;

            // Operand latch: the ALU sees these until the next accepted request.
            if (accept) begin
                alu_a   <= req_a;
                alu_b   <= req_b;
                alu_op  <= req_op;
                alu_inv <= req_inv;
                alu_cin <= req_cin_sel ? p_c : req_cin;
                fmask   <= req_fmask;
                dec_req <= dec_mode && (req_op == OP_SUM);
            end

            // Binary capture; an ADJ cycle that follows overrides data, N, Z and C.
            if (state == ST_EXEC) begin
                rsp_data <= alu_out;
                if (fmask[3])             p_n <= alu_out[7];
                if (fmask[2] && (alu_op == OP_SUM)) p_v <= alu_ovf;
                if (fmask[1])             p_z <= alu_zero;
                if (fmask[0] && carry_op) p_c <= alu_cout;
            end

            if (state == ST_ADJ) begin
                rsp_data <= adj_res[7:0];
                if (fmask[3]) p_n <= adj_res[7];
                if (fmask[1]) p_z <= (adj_res[7:0] == 8'h00);
                if (fmask[0]) p_c <= adj_res[8];
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage with a behavioural ALU and reference model.
module tb_alu_operand_stage;

`ifdef DECIMAL_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a, req_b;
    logic       req_inv, req_cin, req_cin_sel;
    logic [3:0] req_fmask;
    logic       dec_mode;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic       alu_inv, alu_cin;
    logic [7:0] alu_out;
    logic       alu_cout, alu_zero, alu_ovf;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       p_n, p_v, p_z, p_c;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_inv(req_inv), .req_cin(req_cin),
        .req_cin_sel(req_cin_sel), .req_fmask(req_fmask), .dec_mode(dec_mode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_inv(alu_inv),
        .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .p_n(p_n), .p_v(p_v), .p_z(p_z), .p_c(p_c)
    );

    // Stand-in combinational ALU driven by the stage's latched outputs.
    logic [7:0] bx;
    logic [8:0] s9;
    always_comb begin
        bx       = alu_inv ? ~alu_b : alu_b;
        s9       = {1'b0, alu_a} + {1'b0, bx} + {8'd0, alu_cin};
        alu_out  = 8'h00;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (alu_op)
            4'd1: begin
                alu_out  = s9[7:0];
                alu_cout = s9[8];
                alu_ovf  = (alu_a[7] == bx[7]) && (s9[7] != alu_a[7]);
            end
            4'd2: alu_out = alu_a & alu_b;
            4'd3: alu_out = alu_a ^ alu_b;
            4'd4: alu_out = alu_a | alu_b;
            4'd5: begin alu_out = {1'b0, alu_a[7:1]};    alu_cout = alu_a[0]; end
            4'd6: begin alu_out = {alu_cin, alu_a[7:1]}; alu_cout = alu_a[0]; end
            default: alu_out = 8'h00;
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    typedef struct {
        logic [7:0] data;
        logic [3:0] flags;
        int         acc;
        int         lat;
    } exp_t;

    exp_t       q[$];
    logic [3:0] mflags;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         rr_mode;
    bit         seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: returns {N,V,Z,C, result} from plain integer arithmetic.
    function automatic logic [11:0] model(input int op, input int a, input int b,
                                          input int inv, input int cin, input logic [3:0] fm,
                                          input bit dec, input logic [3:0] fl);
        int bb, r, c, v, s, sa, sb, h, hi, r2;
        logic [3:0] nf;
        bb = inv ? (255 - b) : b;
        r = 0; c = -1; v = -1;
        case (op)
            1: begin
                s  = a + bb + cin;
                r  = s % 256;
                c  = s / 256;
                sa = (a > 127) ? a - 256 : a;
                sb = (bb > 127) ? bb - 256 : bb;
                v  = ((sa + sb + cin) > 127 || (sa + sb + cin) < -128) ? 1 : 0;
                if (dec) begin
                    h = ((a % 16) + (bb % 16) + cin) > 15 ? 1 : 0;
                    if (inv == 0) begin
                        r2 = r;
                        if ((r % 16) > 9 || h == 1) r2 = r2 + 6;
                        hi = (r > 153 || c == 1) ? 1 : 0;
                        if (hi == 1) r2 = r2 + 96;
                        r = r2 % 256;
                        c = hi;
                    end else begin
                        r2 = r + 512;
                        if (h == 0) r2 = r2 - 6;
                        if (c == 0) r2 = r2 - 96;
                        r = r2 % 256;
                    end
                end
            end
            2: r = a & b;
            3: r = a ^ b;
            4: r = a | b;
            5: begin r = a / 2;             c = a % 2; end
            6: begin r = cin * 128 + a / 2; c = a % 2; end
            default: r = 0;
        endcase
        nf = fl;
        if (fm[3]) nf[3] = (r >= 128);
        if (fm[2] && v >= 0) nf[2] = (v == 1);
        if (fm[1]) nf[1] = (r == 0);
        if (fm[0] && c >= 0) nf[0] = (c == 1);
        return {nf, r[7:0]};
    endfunction

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic inv, input logic cin, input logic csel,
                         input logic [3:0] fm, input logic dec, output int waits);
        logic [11:0] r;
        exp_t e;
        bit d;
        req_op = op; req_a = a; req_b = b; req_inv = inv; req_cin = cin;
        req_cin_sel = csel; req_fmask = fm; dec_mode = dec; req_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        d = DEC_EN && dec && (op == 4'd1);
        r = model(int'(op), int'(a), int'(b), int'(inv),
                  csel ? int'(mflags[0]) : int'(cin), fm, d, mflags);
        mflags  = r[11:8];
        e.data  = r[7:0];
        e.flags = r[11:8];
        e.acc   = cyc + 1;
        e.lat   = d ? 2 : 1;
        q.push_back(e);
        @(posedge clk);
        #2;
        // Scramble request fields after acceptance; the stage must ignore them.
        req_valid = 1'b0;
        req_op = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
        req_inv = 1'($urandom); req_cin = 1'($urandom); req_cin_sel = 1'($urandom);
        req_fmask = 4'($urandom); dec_mode = 1'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", q.size(), 0);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares every cycle a response is presented, pops on handshake.
    initial begin
        seen = 0;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    if (!seen) begin
                        check("latency", cyc - q[0].acc, q[0].lat);
                        seen = 1;
                    end
                    check("rsp_data", rsp_data, q[0].data);
                    check("flags_nvzc", {p_n, p_v, p_z, p_c}, q[0].flags);
                    check("hold_req_ready", req_ready, rsp_ready);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 0) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [3:0] op;
        rr_mode = 1; rsp_ready = 1'b0; rst_n = 1'b0; req_valid = 1'b0;
        req_op = 0; req_a = 0; req_b = 0; req_inv = 0; req_cin = 0;
        req_cin_sel = 0; req_fmask = 0; dec_mode = 0; mflags = 4'b0000;
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
        check("rst_alu_ctl", {alu_op, alu_inv, alu_cin}, 6'd0);
        check("rst_flags", {p_n, p_v, p_z, p_c}, 4'b0000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #2;

        rsp_ready = 1'b1;
        issue(4'd1, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, w);
        issue(4'd1, 8'h05, 8'h05, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, w);
        issue(4'd6, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, w);
        issue(4'd2, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, w);
        wait_drain();
        check("and_z_only_data", rsp_data, 8'h00);
        check("and_z_only_flags", {p_n, p_v, p_z, p_c}, 4'b1011);

        rsp_ready = 1'b0;
        issue(4'd3, 8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, w);
        w = 0;
        while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
        repeat (3) begin
            @(negedge clk);
            check("bp_req_ready", req_ready, 0);
        end
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        issue(4'd4, 8'h12, 8'h81, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, w);
        check("drain_accept_waits", w, 0);
        wait_drain();

        rr_mode = 0;
        repeat (300) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
            issue(op, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom), 1'($urandom), w);
        end
        rr_mode = 1; rsp_ready = 1'b1;
        wait_drain();

        if (DEC_EN) begin
            issue(4'd1, 8'h09, 8'h01, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, w);
            issue(4'd1, 8'h99, 8'h01, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, w);
            wait_drain();
            check("bcd_99p01_data", rsp_data, 8'h00);
            check("bcd_99p01_cz", {p_z, p_c}, 2'b11);
        end

        issue(4'd1, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, w);
        wait_drain();
        issue(4'd2, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, w);
        check("exec_req_ready", req_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_flags", {p_n, p_v, p_z, p_c}, 4'b0000);
        check("midrst_rsp_data", rsp_data, 8'h00);
        q.delete();
        seen = 0;
        mflags = 4'b0000;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #2;
        issue(4'd5, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, w);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
